// File: rtl/moore_pkg.sv
// moore_pkg
//   State encoding shared by the serial pattern generator and the Moore
//   sequence detectors that consume its bit stream.
package moore_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/moore_seq_gen.sv
// moore_seq_gen
//   Serial test-pattern transmitter. A parallel word is captured on an accepted
//   start and shifted out MSB-first on x, one bit per clock. The frame repeats
//   max(reps,1) times with GAP_CYC idle cycles between frames. A one-cycle done
//   pulse follows the last bit of the last frame.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request, sampled only in IDLE
//   data     in   pattern word [DATA_W-1:0], captured on accept
//   reps     in   frame count [REP_W-1:0], 0 behaves as 1
//   x        out  serial bit, 0 whenever x_valid is low
//   x_valid  out  x carries a pattern bit
//   busy     out  high from accept through the done cycle
//   done     out  one-cycle end-of-transaction pulse
//
// All outputs are decoded from state and registers only.
module moore_seq_gen
    import moore_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REP_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [REP_W-1:0]  reps,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = ($clog2(DATA_W) > 0) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    // Gap counter counts GAP_CYC-1 down to 0, one GAP cycle per value.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_shreg;
    logic [DATA_W-1:0]  r_word;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [REP_W-1:0]   r_rep_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic               w_frame_end;
    logic               w_last_rep;

    assign w_frame_end = (r_state == S_SHIFT) && (r_bit_cnt == '0);
    // Compare before decrementing so reps at full scale never wraps.
    assign w_last_rep  = (r_rep_cnt == REP_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_frame_end) begin
                    if (w_last_rep) begin
                        w_next = S_DONE;
                    end else if (GAP_CYC > 0) begin
                        w_next = S_GAP;
                    end else begin
                        w_next = S_SHIFT;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next = S_SHIFT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shift register and down-counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= '0;
            r_word    <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_word    <= data;
                        r_shreg   <= data;
                        r_bit_cnt <= BIT_LAST;
                        r_rep_cnt <= (reps == '0) ? REP_W'(1) : reps;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == '0) begin
                        // Reload at frame end so the next frame (after any gap)
                        // starts from the MSB of the captured word.
                        r_rep_cnt <= r_rep_cnt - REP_W'(1);
                        r_bit_cnt <= BIT_LAST;
                        r_shreg   <= r_word;
                        r_gap_cnt <= GAP_LOAD;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                        r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x       = (r_state == S_SHIFT) & r_shreg[DATA_W-1];
    assign x_valid = (r_state == S_SHIFT);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_moore_seq_gen.sv
// tb_moore_seq_gen
//   Scoreboard bench for moore_seq_gen. Accepted requests expand into the
//   expected per-cycle output stream; a monitor pops one entry per cycle.
//   A second instance with no gap feeds a 1011 detector for the loopback case.
module tb_moore_seq_gen;

    localparam int DW  = 8;
    localparam int RW  = 4;
    localparam int GAP = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data  = '0;
    logic [RW-1:0] reps  = '0;
    logic          x, x_valid, busy, done;

    logic          start0 = 1'b0;
    logic [DW-1:0] data0  = '0;
    logic [RW-1:0] reps0  = '0;
    logic          x0, xv0, busy0, done0;

    int total = 0;
    int bad   = 0;

    // Expected entries: {busy, x_valid, x, done}
    logic [3:0] exp_q[$];
    int         model_cnt = 0;

    moore_seq_gen #(.DATA_W(DW), .REP_W(RW), .GAP_CYC(GAP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .reps(reps),
        .x(x), .x_valid(x_valid), .busy(busy), .done(done)
    );

    moore_seq_gen #(.DATA_W(DW), .REP_W(RW), .GAP_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data0), .reps(reps0),
        .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frames(input logic [RW-1:0] r);
        return (r == 0) ? 1 : int'(r);
    endfunction

    function automatic int txn_len(input logic [RW-1:0] r);
        return frames(r) * DW + (frames(r) - 1) * GAP + 1;
    endfunction

    function automatic void push_txn(input logic [DW-1:0] d, input logic [RW-1:0] r);
        for (int f = 0; f < frames(r); f++) begin
            for (int k = DW - 1; k >= 0; k--) exp_q.push_back({2'b11, d[k], 1'b0});
            if (f < frames(r) - 1)
                for (int g = 0; g < GAP; g++) exp_q.push_back(4'b1000);
        end
        exp_q.push_back(4'b1001);
    endfunction

    function automatic logic [3:0] exp_pop();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 4'b0000;
    endfunction

    // Reference model: idle/busy bookkeeping and request acceptance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            model_cnt <= 0;
        end else if (model_cnt == 0) begin
            if (start) begin
                push_txn(data, reps);
                model_cnt <= txn_len(reps);
            end
        end else begin
            model_cnt <= model_cnt - 1;
        end
    end

    // Monitor: one expected entry per cycle, idle pattern when nothing is queued
    always @(negedge clk) begin
        check("stream", {28'd0, busy, x_valid, x, done}, {28'd0, exp_pop()});
    end

    // Loopback detector for 1011 on the gap-free instance
    logic [3:0] det_win    = '0;
    logic       det_z_prev = 1'b0;
    logic       det_z;
    int         rises = 0, vcnt = 0, first_v = -1, last_v = -1, cyc = 0;
    logic       seen_done0 = 1'b0;

    assign det_z = (det_win == 4'b1011);

    always @(posedge clk) begin
        det_win    <= {det_win[2:0], x0};
        det_z_prev <= det_z;
        if (det_z && !det_z_prev) rises <= rises + 1;
        if (xv0) begin
            vcnt   <= vcnt + 1;
            last_v <= cyc;
            if (first_v < 0) first_v <= cyc;
        end
        if (done0) seen_done0 <= 1'b1;
        cyc <= cyc + 1;
    end

    task automatic wait_idle(input int budget);
        int i = 0;
        while (model_cnt != 0 && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (model_cnt != 0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got %0d cycles left expected 0", model_cnt);
        end
    endtask

    task automatic go(input logic [DW-1:0] d, input logic [RW-1:0] r);
        wait_idle(400);
        data  = d;
        reps  = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_x"},       {31'd0, x},       32'd0);
        check({tag, "_x_valid"}, {31'd0, x_valid}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy},    32'd0);
        check({tag, "_done"},    {31'd0, done},    32'd0);
    endtask

    initial begin
        // Asynchronous reset with no clock edge
        #1 rst = 1'b1;
        #1 check_outs_zero("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single frame, then repeated frames with gaps, then reps=0
        go(8'b1011_0000, 4'd1);
        go(8'hA5, 4'd3);
        go(8'h3C, 4'd0);

        // Start and data/reps changes while busy are ignored
        go(8'h96, 4'd2);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        data  = 8'hFF;
        reps  = 4'hF;
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = 8'h00;

        // Maximum repetition count
        go(8'($urandom), 4'hF);

        // Start held high: re-accepts only after returning to IDLE
        wait_idle(400);
        data  = 8'hC3;
        reps  = 4'd1;
        start = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;

        // rst together with start: rst wins
        wait_idle(400);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        data  = 8'h5A;
        reps  = 4'd1;
        @(posedge clk);
        #1;
        check_outs_zero("rst_with_start");
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset during bit 4 of frame 2, then a clean full frame
        go(8'hE7, 4'd3);
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outs_zero("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        go(8'hE7, 4'd1);

        // Randomized transactions with occasional ignored requests
        for (int t = 0; t < 15; t++) begin
            go(8'($urandom), 4'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
                start = 1'b1;
                data  = 8'($urandom);
                reps  = 4'($urandom);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        wait_idle(400);

        // Loopback through the 1011 detector, no gap between frames
        @(posedge clk);
        #1;
        data0  = 8'b0010_1100;
        reps0  = 4'd2;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        data0  = 8'hFF;
        begin
            int i = 0;
            while (!seen_done0 && i < 60) begin
                @(posedge clk);
                #1;
                i++;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check("loop_done_seen", {31'd0, seen_done0}, 32'd1);
        check("loop_z_rises",   rises,               32'd2);
        check("loop_valid_cnt", vcnt,                32'd16);
        check("loop_valid_span", last_v - first_v + 1, 32'd16);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
